// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial subtractor. Computes diff = a - b - bin (mod 2^WIDTH), one bit
//   per clock, LSB first, through a single full-subtractor cell and a
//   registered borrow. An operation is requested with start, runs for WIDTH
//   busy cycles and ends with a one-cycle done pulse. diff/bout/ovf are held
//   until the next operation completes.
//
// Ports
//   clk     in   1      rising-edge clock
//   rst_n   in   1      synchronous active-low reset
//   start   in   1      request, accepted only while busy==0
//   a       in   WIDTH  minuend, sampled in the accept cycle
//   b       in   WIDTH  subtrahend, sampled in the accept cycle
//   bin     in   1      borrow-in, sampled in the accept cycle
//   busy    out  1      operation in progress
//   done    out  1      one-cycle pulse, results newly updated
//   diff    out  WIDTH  a - b - bin (mod 2^WIDTH)
//   bout    out  1      final borrow-out
//   ovf     out  1      signed two's-complement overflow
//
// State table
//   state | meaning
//   IDLE  | waiting for start
//   SHIFT | processing bit cnt_q of the latched operands
//   DONE  | results valid for one cycle; start here is accepted immediately
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               br_q, br_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;
    logic               ovf_q, ovf_d;

    logic a_bit, b_bit, d_bit, br_next;

    // Full-subtractor cell on the current LSBs of the operand shift registers.
    assign a_bit   = a_q[0];
    assign b_bit   = b_q[0];
    assign d_bit   = a_bit ^ b_bit ^ br_q;
    assign br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end

            SHIFT: begin
                // Result bits enter a_q from the top as operand bits leave the
                // bottom, so after WIDTH steps a_q would hold the difference.
                a_d   = {d_bit, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                br_d  = br_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // a_bit/b_bit are the operand MSBs and d_bit is diff MSB here.
                    cnt_d   = '0;
                    diff_d  = {d_bit, a_q[WIDTH-1:1]};
                    bout_d  = br_next;
                    ovf_d   = (a_bit != b_bit) && (d_bit != a_bit);
                    state_d = DONE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor (WIDTH=8). Directed timeline checks plus a
// scoreboard: expected results are queued when an op is issued and compared
// by a monitor whenever done is seen.
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         busy, done, bout, ovf;
    logic [W-1:0] diff;

    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;
    exp_t sb[$];
    exp_t e_mon;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .bin  (bin),
        .busy (busy),
        .done (done),
        .diff (diff),
        .bout (bout),
        .ovf  (ovf)
    );

    always #5 clk = ~clk;

    // Monitor: sample away from the active edge, pop scoreboard on done.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            assert ((^{busy, done, diff, bout, ovf}) !== 1'bx) else begin
                failures++;
                $error("FAIL no_x observed=%b_%b_%h_%b_%b expected=no X", busy, done, diff, bout, ovf);
            end
            if (done === 1'b1) begin
                done_cnt++;
                checks++;
                assert (sb.size() > 0) else begin
                    failures++;
                    $error("FAIL unexpected_done observed=done expected=no done (queue empty)");
                end
                if (sb.size() > 0) begin
                    e_mon = sb.pop_front();
                    checks++;
                    assert ({diff, bout, ovf} === {e_mon.d, e_mon.bo, e_mon.ov}) else begin
                        failures++;
                        $error("FAIL result observed=diff %h bout %b ovf %b expected=diff %h bout %b ovf %b",
                               diff, bout, ovf, e_mon.d, e_mon.bo, e_mon.ov);
                    end
                end
            end
        end
    end

    function automatic exp_t mk(logic [W-1:0] d, logic bo, logic ov);
        exp_t e;
        e.d  = d;
        e.bo = bo;
        e.ov = ov;
        return e;
    endfunction

    // Arithmetic reference: widen by one bit, the extra bit is the borrow.
    function automatic exp_t model(logic [W-1:0] av, logic [W-1:0] bv, logic bi);
        logic [W:0] r;
        exp_t e;
        r    = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, bi};
        e.d  = r[W-1:0];
        e.bo = r[W];
        e.ov = (av[W-1] != bv[W-1]) && (e.d[W-1] != av[W-1]);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        chk("wait_idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 40) begin
            tick();
            n++;
        end
        chk("drain_timeout", sb.size(), 32'd0);
    endtask

    // Issue one op; the accept happens at the next rising edge.
    task automatic issue(logic [W-1:0] av, logic [W-1:0] bv, logic bi, exp_t e);
        wait_idle();
        a     = av;
        b     = bv;
        bin   = bi;
        start = 1'b1;
        sb.push_back(e);
        tick();
        start = 1'b0;
        a     = $urandom_range(255, 0);
        b     = $urandom_range(255, 0);
        bin   = 1'($urandom_range(1, 0));
    endtask

    // Cycle-exact op: start in cycle 0, busy 1..8, done 9. A foreign start
    // is pulsed in cycle 3 and diff must hold its previous value while busy.
    task automatic timed_op(logic [W-1:0] av, logic [W-1:0] bv, logic bi, exp_t e,
                            logic [W-1:0] held);
        wait_idle();
        a     = av;
        b     = bv;
        bin   = bi;
        start = 1'b1;
        sb.push_back(e);
        tick();
        for (int i = 1; i <= W; i++) begin
            chk("lat_busy", {31'd0, busy}, 32'd1);
            chk("lat_done_low", {31'd0, done}, 32'd0);
            chk("held_diff", {24'd0, diff}, {24'd0, held});
            if (i == 3) begin
                start = 1'b1;
                a     = 8'hAA;
                b     = 8'h11;
                bin   = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        chk("lat_done", {31'd0, done}, 32'd1);
        chk("lat_busy_low", {31'd0, busy}, 32'd0);
        tick();
        chk("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    initial begin
        int dc;
        logic [W-1:0] ra, rb;
        logic rbi;

        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_diff", {24'd0, diff}, 32'd0);
        chk("rst_bout", {31'd0, bout}, 32'd0);
        chk("rst_ovf",  {31'd0, ovf},  32'd0);
        rst_n = 1'b1;
        tick();

        timed_op(8'h05, 8'h03, 1'b0, mk(8'h02, 1'b0, 1'b0), 8'h00);
        timed_op(8'h03, 8'h05, 1'b0, mk(8'hFE, 1'b1, 1'b0), 8'h02);

        issue(8'h80, 8'h01, 1'b0, mk(8'h7F, 1'b0, 1'b1));
        issue(8'h7F, 8'hFF, 1'b0, mk(8'h80, 1'b1, 1'b1));
        issue(8'h00, 8'h00, 1'b1, mk(8'hFF, 1'b1, 1'b0));
        issue(8'hFF, 8'hFF, 1'b0, mk(8'h00, 1'b0, 1'b0));
        drain();

        // Back-to-back with start held high: done every W+1 cycles.
        wait_idle();
        start = 1'b1;
        a = 8'h12; b = 8'h34; bin = 1'b0;
        sb.push_back(model(8'h12, 8'h34, 1'b0));
        tick();
        repeat (W) tick();
        chk("b2b_done1", {31'd0, done}, 32'd1);
        a = 8'hF0; b = 8'h0F; bin = 1'b1;
        sb.push_back(model(8'hF0, 8'h0F, 1'b1));
        tick();
        repeat (W) tick();
        chk("b2b_done2", {31'd0, done}, 32'd1);
        a = 8'h55; b = 8'h55; bin = 1'b1;
        sb.push_back(model(8'h55, 8'h55, 1'b1));
        tick();
        repeat (W) tick();
        chk("b2b_done3", {31'd0, done}, 32'd1);
        start = 1'b0;
        drain();

        // Reset mid-op: outputs cleared (diff was FF) and no done afterwards.
        wait_idle();
        a = 8'hC3; b = 8'h3C; bin = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        sb.delete();
        tick();
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_diff", {24'd0, diff}, 32'd0);
        chk("mid_rst_bout", {31'd0, bout}, 32'd0);
        chk("mid_rst_ovf",  {31'd0, ovf},  32'd0);
        rst_n = 1'b1;
        dc = done_cnt;
        repeat (20) tick();
        chk("no_done_after_rst", done_cnt, dc);

        // Random ops against the arithmetic reference.
        for (int k = 0; k < 300; k++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            rbi = 1'($urandom_range(1, 0));
            issue(ra, rb, rbi, model(ra, rb, rbi));
            repeat ($urandom_range(2, 0)) tick();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
